// File: rtl/key_bounce_gen.sv
// rtl/key_bounce_gen.sv - mechanical key emulator producing pseudo-random contact bounce
//
// On press_req (from the released state) key_out bounces for a fixed window and
// settles low; on release_req (from the pressed state) it bounces and settles
// high. Bounce segment lengths come from a free-running 16-bit LFSR.
//
// Optional feature macro: KEY_BOUNCE_EDGE_CNT_EN adds the bounce_edges output.
//
// Ports:
//   clk          in   system clock
//   rstn         in   asynchronous active-low reset
//   press_req    in   single-cycle press command (acts only when released)
//   release_req  in   single-cycle release command (acts only when pressed)
//   key_out      out  emulated key line, active low
//   busy         out  high while a bounce window is in progress
//   done         out  one-cycle pulse when key_out reaches its final level
//   key_level    out  settled logical level (1 = released, 0 = pressed)
//   bounce_edges out  [7:0] key_out transitions in the last window, saturating
//                     (present only with KEY_BOUNCE_EDGE_CNT_EN)

module key_bounce_gen #(
  parameter int          BOUNCE_CYC = 250000,
  parameter int          SEG_MIN    = 500,
  parameter int          SEG_MASK   = 4095,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       press_req,
  input  logic       release_req,
  output logic       key_out,
  output logic       busy,
  output logic       done,
  output logic       key_level
`ifdef KEY_BOUNCE_EDGE_CNT_EN
  ,
  output logic [7:0] bounce_edges
`endif
);

  localparam int WIN_W     = $clog2(BOUNCE_CYC);
  localparam int SEG_W_RAW = $clog2(SEG_MIN + SEG_MASK + 1);
  localparam int SEG_W     = (SEG_W_RAW > 20) ? SEG_W_RAW : 20;

  localparam logic [15:0]      SEED     = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;
  localparam logic [15:0]      MASK16   = SEG_MASK[15:0];
  localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(BOUNCE_CYC - 1);
  localparam logic [SEG_W-1:0] SEG_BASE = SEG_W'(SEG_MIN);

  typedef enum logic [3:0] {
    UP        = 4'b0001,
    BOUNCE_DN = 4'b0010,
    DOWN      = 4'b0100,
    BOUNCE_UP = 4'b1000
  } state_t;

  state_t           state;
  logic [15:0]      lfsr;
  logic [WIN_W-1:0] win_cnt;
  logic [SEG_W-1:0] seg_cnt;

  // Fibonacci LFSR, x^16 + x^14 + x^13 + x^11 + 1; free-running in every state.
  logic lfsr_fb;
  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) lfsr <= SEED;
    else       lfsr <= {lfsr[14:0], lfsr_fb};
  end

  // Next segment length. A zero length would wrap the down-counter, so it is
  // clamped to one cycle (only reachable with SEG_MIN = 0).
  logic [SEG_W-1:0] seg_rand;
  logic [SEG_W-1:0] seg_load;
  always_comb begin
    seg_rand = SEG_BASE + SEG_W'(lfsr & MASK16);
    seg_load = (seg_rand == '0) ? SEG_W'(1) : seg_rand;
  end

  // Decisions use the post-decrement values: win_cnt is loaded with
  // BOUNCE_CYC-1 in the first bounce cycle, so the window closes after exactly
  // BOUNCE_CYC-1 bounce cycles and the final level appears on the next edge.
  logic [WIN_W-1:0] win_dec;
  logic [SEG_W-1:0] seg_dec;
  logic             fin_level;
  assign win_dec   = win_cnt - WIN_W'(1);
  assign seg_dec   = seg_cnt - SEG_W'(1);
  assign fin_level = (state == BOUNCE_UP);

`ifdef KEY_BOUNCE_EDGE_CNT_EN
  logic [7:0] edge_cnt;
  logic [7:0] edge_inc;
  assign edge_inc = (edge_cnt == 8'hFF) ? edge_cnt : edge_cnt + 8'd1;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= UP;
      key_out      <= 1'b1;
      key_level    <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      win_cnt      <= '0;
      seg_cnt      <= '0;
`ifdef KEY_BOUNCE_EDGE_CNT_EN
      edge_cnt     <= 8'd0;
      bounce_edges <= 8'd0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        UP: begin
          if (press_req) begin
            state    <= BOUNCE_DN;
            key_out  <= 1'b0;
            busy     <= 1'b1;
            win_cnt  <= WIN_LOAD;
            seg_cnt  <= seg_load;
`ifdef KEY_BOUNCE_EDGE_CNT_EN
            edge_cnt <= 8'd1;
`endif
          end
        end

        DOWN: begin
          if (release_req) begin
            state    <= BOUNCE_UP;
            key_out  <= 1'b1;
            busy     <= 1'b1;
            win_cnt  <= WIN_LOAD;
            seg_cnt  <= seg_load;
`ifdef KEY_BOUNCE_EDGE_CNT_EN
            edge_cnt <= 8'd1;
`endif
          end
        end

        BOUNCE_DN, BOUNCE_UP: begin
          win_cnt <= win_dec;
          if (win_dec == '0) begin
            // Window over: force the settled level, discarding any pending toggle.
            key_out   <= fin_level;
            key_level <= fin_level;
            busy      <= 1'b0;
            done      <= 1'b1;
            seg_cnt   <= '0;
            state     <= fin_level ? UP : DOWN;
`ifdef KEY_BOUNCE_EDGE_CNT_EN
            // The forced edge only counts if key_out actually changes.
            bounce_edges <= (key_out != fin_level) ? edge_inc : edge_cnt;
`endif
          end else if (seg_dec == '0) begin
            key_out  <= ~key_out;
            seg_cnt  <= seg_load;
`ifdef KEY_BOUNCE_EDGE_CNT_EN
            edge_cnt <= edge_inc;
`endif
          end else begin
            seg_cnt <= seg_dec;
          end
        end

        default: begin
          state     <= UP;
          key_out   <= 1'b1;
          key_level <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_bounce_gen.sv
// tb/tb_key_bounce_gen.sv - directed self-checking bench for key_bounce_gen
//
// dut  : BOUNCE_CYC=64, SEG_MIN=4, SEG_MASK=7 (bouncing window)
// dut2 : BOUNCE_CYC=64, SEG_MIN=70 (segment longer than window -> clean edge)
// Both instances share clock, reset and commands.

module tb_key_bounce_gen;

  logic clk;
  logic rstn;
  logic press_req;
  logic release_req;
  logic key_out, busy, done, key_level;
  logic key_out2, busy2, done2, key_level2;
`ifdef KEY_BOUNCE_EDGE_CNT_EN
  logic [7:0] bounce_edges, bounce_edges2;
`endif

  key_bounce_gen #(
    .BOUNCE_CYC(64), .SEG_MIN(4), .SEG_MASK(7), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .rstn(rstn), .press_req(press_req), .release_req(release_req),
    .key_out(key_out), .busy(busy), .done(done), .key_level(key_level)
`ifdef KEY_BOUNCE_EDGE_CNT_EN
    , .bounce_edges(bounce_edges)
`endif
  );

  key_bounce_gen #(
    .BOUNCE_CYC(64), .SEG_MIN(70), .SEG_MASK(7), .LFSR_SEED(16'h0000)
  ) dut2 (
    .clk(clk), .rstn(rstn), .press_req(press_req), .release_req(release_req),
    .key_out(key_out2), .busy(busy2), .done(done2), .key_level(key_level2)
`ifdef KEY_BOUNCE_EDGE_CNT_EN
    , .bounce_edges(bounce_edges2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Steps until done (bounded); lat = cycles from the first bounce cycle, -1 on timeout.
  task automatic wait_done(input int budget, output int lat, output int busy_miss);
    lat       = -1;
    busy_miss = 0;
    for (int i = 1; i <= budget; i++) begin
      step();
      if (done) begin
        lat = i;
        break;
      end
      if (!busy) busy_miss++;
    end
  endtask

  // Monitor: edge counting, segment gap check, and a reference debounce filter.
  int   cyc = 0, last_edge = 0, win_edges = 0, gap_bad = 0, edges2 = 0;
  int   stable = 0, ev_press = 0, ev_release = 0;
  bit   last_valid = 1'b0, fresh = 1'b1;
  logic prev_key = 1'b1, prev_key2 = 1'b1, filt = 1'b1;

  always @(negedge clk) begin
    cyc++;
    if (rstn && (busy || done) && key_out !== prev_key) begin
      if (fresh) win_edges = 1;
      else       win_edges++;
      fresh = 1'b0;
      if (last_valid && !done && (cyc - last_edge < 4 || cyc - last_edge > 11)) gap_bad++;
      last_valid = 1'b1;
      last_edge  = cyc;
    end
    if (!busy && !done) begin
      fresh      = 1'b1;
      last_valid = 1'b0;
    end
    prev_key = key_out;
    if (rstn && key_out2 !== prev_key2) edges2++;
    prev_key2 = key_out2;
    if (key_out === filt) stable = 0;
    else begin
      stable++;
      if (stable >= 16) begin
        filt   = key_out;
        stable = 0;
        if (filt == 1'b0) ev_press++;
        else              ev_release++;
      end
    end
  end

  int lat, bmiss, e2, bad, dones, done_at;

  initial begin
    rstn = 1'b0; press_req = 1'b0; release_req = 1'b0;
    repeat (5) step();
    rstn = 1'b1;
    check_eq("rst_key_out", key_out, 1);
    check_eq("rst_key_level", key_level, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    step();

    // release_req in UP is ignored
    release_req = 1'b1; step(); release_req = 1'b0;
    check_eq("rel_in_up_busy", busy, 0);
    check_eq("rel_in_up_key", key_out, 1);
    step();

    // press
    e2 = edges2;
    press_req = 1'b1; step(); press_req = 1'b0;
    check_eq("press_first_edge", key_out, 0);
    check_eq("press_busy", busy, 1);
    wait_done(80, lat, bmiss);
    check_eq("press_latency", lat, 63);
    check_eq("press_busy_gap", bmiss, 0);
    check_eq("press_final_key", key_out, 0);
    check_eq("press_final_level", key_level, 0);
    check_eq("press_busy_at_done", busy, 0);
    step();
    check_eq("press_done_pulse", done, 0);
    check_eq("press_gap_range", gap_bad, 0);
    check_eq("press_edges_odd", win_edges % 2, 1);
    check_eq("press_clean_edges", edges2 - e2, 1);
`ifdef KEY_BOUNCE_EDGE_CNT_EN
    check_eq("press_bounce_edges", bounce_edges, win_edges);
    check_eq("press_bounce_edges_clean", bounce_edges2, 1);
`endif
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (key_out !== 1'b0 || done !== 1'b0) bad++;
    end
    check_eq("press_hold_low", bad, 0);

    // release from DOWN
    e2 = edges2;
    release_req = 1'b1; step(); release_req = 1'b0;
    check_eq("rel_first_edge", key_out, 1);
    check_eq("rel_busy", busy, 1);
    wait_done(80, lat, bmiss);
    check_eq("rel_latency", lat, 63);
    check_eq("rel_final_key", key_out, 1);
    check_eq("rel_final_level", key_level, 1);
    step();
    check_eq("rel_gap_range", gap_bad, 0);
    check_eq("rel_edges_odd", win_edges % 2, 1);
    check_eq("rel_clean_edges", edges2 - e2, 1);
`ifdef KEY_BOUNCE_EDGE_CNT_EN
    check_eq("rel_bounce_edges", bounce_edges, win_edges);
    check_eq("rel_bounce_edges_clean", bounce_edges2, 1);
`endif
    repeat (40) step();
    check_eq("debounce_press_events", ev_press, 1);
    check_eq("debounce_release_events", ev_release, 1);

    // commands while busy are dropped
    e2 = edges2;
    press_req = 1'b1; step(); press_req = 1'b0;
    dones = 0; done_at = -1;
    for (int k = 2; k <= 70; k++) begin
      step();
      if (done) begin
        dones++;
        done_at = k;
      end
      press_req   = (k == 10 || k == 30);
      release_req = (k == 10 || k == 30);
    end
    press_req = 1'b0; release_req = 1'b0;
    check_eq("drop_done_count", dones, 1);
    check_eq("drop_done_at", done_at, 64);
    check_eq("drop_level", key_level, 0);
    check_eq("drop_key", key_out, 0);
    check_eq("drop_clean_edges", edges2 - e2, 1);

    // press_req in DOWN is ignored
    press_req = 1'b1; step(); press_req = 1'b0;
    check_eq("press_in_down_busy", busy, 0);
    check_eq("press_in_down_key", key_out, 0);
    step();
    release_req = 1'b1; step(); release_req = 1'b0;
    wait_done(80, lat, bmiss);
    check_eq("back_up_latency", lat, 63);
    step();

    // reset mid-burst
    press_req = 1'b1; step(); press_req = 1'b0;
    repeat (19) step();
    check_eq("mid_busy_before_rst", busy, 1);
    #2 rstn = 1'b0;
    #1;
    check_eq("mid_rst_key", key_out, 1);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_level", key_level, 1);
    step(); step();
    rstn = 1'b1;
    step();
    press_req = 1'b1; step(); press_req = 1'b0;
    check_eq("post_rst_first_edge", key_out, 0);
    wait_done(80, lat, bmiss);
    check_eq("post_rst_latency", lat, 63);
    check_eq("post_rst_level", key_level, 0);
    step();
    check_eq("post_rst_gap_range", gap_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
